// File: rtl/test_runner_pkg.sv
// Shared definitions for the test-fixture sequencer and the board tops that
// decode its status.
//   state_t  : sequencer state encoding (IDLE=0, ARM=1, WAIT=2, GAP=3, DONE=4)
//   LED_*    : status LED codes, bit order {r, g, b}
//   led_code : maps a sequencer state and verdict to an LED code. In the
//              failing DONE state the red bit means "blink red".
package test_runner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [2:0] LED_OFF   = 3'b000;
  localparam logic [2:0] LED_BLUE  = 3'b001;
  localparam logic [2:0] LED_GREEN = 3'b010;
  localparam logic [2:0] LED_RED   = 3'b100;

  function automatic logic [2:0] led_code(state_t s, logic pass_all);
    case (s)
      ST_ARM, ST_WAIT, ST_GAP: return LED_BLUE;
      ST_DONE:                 return pass_all ? LED_GREEN : LED_RED;
      default:                 return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/test_runner_if.sv
// Fixture-side and status signals of the sequencer.
//   master : the sequencer (drives o_*, dbg_state; samples i_*)
//   slave  : fixtures / board logic (drives i_*; samples o_*)
// Handshake per fixture k: the sequencer holds o_run[k] high as a level; the
// fixture raises i_running[k] once it has started and drops it when done,
// with i_passed[k] valid in the cycle i_running[k] is first seen low.
// There is no back-pressure; a fixture that never starts or never finishes is
// cut off by the per-fixture timeout.
interface test_runner_if #(
  parameter int N_TESTS = 2
);
  import test_runner_pkg::*;

  logic               i_start;
  logic [N_TESTS-1:0] o_run;
  logic [N_TESTS-1:0] i_running;
  logic [N_TESTS-1:0] i_passed;
  logic               o_busy;
  logic               o_done;
  logic               o_pass_all;
  logic [N_TESTS-1:0] o_fail_mask;
  logic               o_led_r;
  logic               o_led_g;
  logic               o_led_b;
  state_t             dbg_state;

  modport master (
    input  i_start, i_running, i_passed,
    output o_run, o_busy, o_done, o_pass_all, o_fail_mask,
           o_led_r, o_led_g, o_led_b, dbg_state
  );

  modport slave (
    output i_start, i_running, i_passed,
    input  o_run, o_busy, o_done, o_pass_all, o_fail_mask,
           o_led_r, o_led_g, o_led_b, dbg_state
  );

endinterface

// File: rtl/test_runner_blink_gen.sv
// Failure blinker. While en is high the output is on for BLINK_DIV cycles,
// off for BLINK_DIV cycles, and so on, starting on in the first cycle after
// en rises. Dropping en clears the divider and turns the output off.
// Ports: clk, rst (sync, active-high), en, blink (registered).
module test_runner_blink_gen #(
  parameter int BLINK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic blink
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic          blink_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      blink_q  <= 1'b0;
    end else if (!active_q) begin
      // first enabled cycle: come up in the on phase
      cnt_q    <= '0;
      active_q <= 1'b1;
      blink_q  <= 1'b1;
    end else if (cnt_q == CMAX) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/test_runner.sv
// Sequencer for self-checking test fixtures. Runs fixtures 0..N_TESTS-1 in
// turn through the run/running/passed handshake, collects a fail mask and
// shows the outcome on an RGB LED (blue busy, green pass, red blink fail).
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : test_runner_if.master (start, run strobes, fixture status,
//                  verdict, LEDs, debug state)
// Parameters: N_TESTS fixtures, TIMEOUT cycles per fixture measured from its
// run strobe, BLINK_DIV half-period of the failure blink.
module test_runner
  import test_runner_pkg::*;
#(
  parameter int N_TESTS   = 2,
  parameter int TIMEOUT   = 1024,
  parameter int BLINK_DIV = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  test_runner_if.master bus
);

  localparam int KW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [KW-1:0] KLAST = KW'(N_TESTS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [TW-1:0]      timer_q, timer_d, timer_inc;
  logic [N_TESTS-1:0] mask_q, mask_d;
  logic               expired;

  logic [N_TESTS-1:0] run_q, run_d;
  logic               busy_q, done_q, pass_q, led_g_q, led_b_q;
  logic               pass_d;
  logic [2:0]         led_d;

  // Saturating so a long-hung fixture cannot wrap the timer back below TLAST.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
  assign expired   = (timer_q >= TLAST);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mask_d  = mask_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_d = ST_ARM;
          k_d     = '0;
          mask_d  = '0;
          timer_d = '0;
        end
      end
      ST_ARM: begin
        timer_d = timer_inc;
        if (bus.i_running[k_q]) begin
          state_d = ST_WAIT;
        end else if (expired) begin
          mask_d[k_q] = 1'b1;
          state_d     = ST_GAP;
        end
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        // a finishing fixture wins over a simultaneous timeout
        if (!bus.i_running[k_q]) begin
          if (!bus.i_passed[k_q]) mask_d[k_q] = 1'b1;
          state_d = ST_GAP;
        end else if (expired) begin
          mask_d[k_q] = 1'b1;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        timer_d = '0;
        if (k_q == KLAST) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    run_d  = '0;
    pass_d = (mask_d == '0);
    if (state_d == ST_ARM || state_d == ST_WAIT) run_d = N_TESTS'(1) << k_d;
    led_d  = led_code(state_d, pass_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      timer_q <= '0;
      mask_q  <= '0;
      run_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
      run_q   <= run_d;
      busy_q  <= (state_d == ST_ARM) || (state_d == ST_WAIT) || (state_d == ST_GAP);
      done_q  <= (state_d == ST_DONE);
      pass_q  <= (state_d == ST_DONE) && pass_d;
      led_g_q <= led_d[1];
      led_b_q <= led_d[0];
    end
  end

  // The red bit of the LED code enables the blinker, whose register is the LED.
  test_runner_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (led_d[2]),
    .blink (bus.o_led_r)
  );

  assign bus.o_run       = run_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_pass_all  = pass_q;
  assign bus.o_fail_mask = mask_q;
  assign bus.o_led_g     = led_g_q;
  assign bus.o_led_b     = led_b_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_test_runner.sv
// Bench for test_runner: two stub fixtures with selectable behaviour, a table
// of whole-sequence scenarios, and hand-written sequences for run timing,
// timeout timing, reset mid-sequence and restart from DONE.
module tb_test_runner;
  import test_runner_pkg::*;

  localparam int N  = 2;
  localparam int TO = 32;
  localparam int BD = 16;

  localparam int M_OK    = 0;  // runs 5 cycles, then reports fx_pass
  localparam int M_NEVER = 1;  // never raises running
  localparam int M_HANG  = 2;  // raises running and never drops it

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  test_runner_if #(.N_TESTS(N)) bus ();

  test_runner #(.N_TESTS(N), .TIMEOUT(TO), .BLINK_DIV(BD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- stub fixtures ----------------
  int   fx_mode[N];
  logic fx_pass[N];
  int   fx_cnt[N];

  initial begin
    bus.i_running = '0;
    bus.i_passed  = '0;
    for (int k = 0; k < N; k++) begin
      fx_mode[k] = M_OK;
      fx_pass[k] = 1'b1;
      fx_cnt[k]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        bus.i_passed[k] = fx_pass[k];
        if (!bus.o_run[k]) begin
          bus.i_running[k] = 1'b0;
          fx_cnt[k] = 0;
        end else begin
          case (fx_mode[k])
            M_NEVER: bus.i_running[k] = 1'b0;
            M_HANG:  bus.i_running[k] = 1'b1;
            default: begin
              bus.i_running[k] = (fx_cnt[k] < 5);
              if (fx_cnt[k] < 5) fx_cnt[k] = fx_cnt[k] + 1;
            end
          endcase
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fx(input int m0, input int m1, input logic p0, input logic p1);
    fx_mode[0] = m0;
    fx_mode[1] = m1;
    fx_pass[0] = p0;
    fx_pass[1] = p1;
  endtask

  // Returns at the negedge of the first cycle after i_start was sampled (n=0).
  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Counts cycles from n=0 until o_done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int         m0;
    int         m1;
    logic       p0;
    logic       p1;
    logic [1:0] exp_mask;
    logic       exp_pass;
    int         exp_cyc;   // cycle index of o_done rising, n=0 is first ARM cycle
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    // Fixture span: 6 cycles for a normal 5-cycle run, 32 for a timeout;
    // done arrives at span0 + 1 gap + span1 + 1 gap.
    vecs[0] = '{M_OK,    M_OK,   1'b1, 1'b1, 2'b00, 1'b1, 14};
    vecs[1] = '{M_OK,    M_OK,   1'b1, 1'b0, 2'b10, 1'b0, 14};
    vecs[2] = '{M_NEVER, M_OK,   1'b1, 1'b1, 2'b01, 1'b0, 40};
    vecs[3] = '{M_OK,    M_HANG, 1'b1, 1'b1, 2'b10, 1'b0, 40};
    vecs[4] = '{M_OK,    M_OK,   1'b0, 1'b0, 2'b11, 1'b0, 14};
    vecs[5] = '{M_NEVER, M_HANG, 1'b1, 1'b1, 2'b11, 1'b0, 66};

    rst = 1'b1;
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("reset state", bus.dbg_state, ST_IDLE);
    check("reset run", bus.o_run, 2'b00);
    check("reset flags", {bus.o_busy, bus.o_done, bus.o_pass_all}, 3'b000);
    check("reset mask", bus.o_fail_mask, 2'b00);
    check("reset leds", {bus.o_led_r, bus.o_led_g, bus.o_led_b}, 3'b000);

    // run-strobe timing, both fixtures passing
    set_fx(M_OK, M_OK, 1'b1, 1'b1);
    for (int i = 0; i <= 14; i++) begin
      if (i <= 5) exp_q.push_back(2'b01);
      else if (i >= 7 && i <= 12) exp_q.push_back(2'b10);
      else exp_q.push_back(2'b00);
    end
    repeat (7) @(negedge clk);
    pulse_start();
    check("start busy", bus.o_busy, 1'b1);
    check("start led_b", bus.o_led_b, 1'b1);
    for (int i = 0; i <= 14; i++) begin
      check($sformatf("run pattern n=%0d", i), bus.o_run, exp_q.pop_front());
      if (i == 13) check("done before last gap", bus.o_done, 1'b0);
      if (i < 14) @(negedge clk);
    end
    check("pattern done", bus.o_done, 1'b1);
    check("pattern pass", bus.o_pass_all, 1'b1);

    // exact timeout cycle for a fixture that never starts
    set_fx(M_NEVER, M_OK, 1'b1, 1'b1);
    pulse_start();
    repeat (31) @(negedge clk);
    check("to n31 mask", bus.o_fail_mask, 2'b00);
    check("to n31 run", bus.o_run, 2'b01);
    @(negedge clk);
    check("to n32 mask", bus.o_fail_mask, 2'b01);
    check("to n32 run", bus.o_run, 2'b00);
    @(negedge clk);
    check("to n33 run", bus.o_run, 2'b10);
    repeat (10) @(negedge clk);

    // table of whole sequences, each restarting from DONE
    for (int v = 0; v < 6; v++) begin
      set_fx(vecs[v].m0, vecs[v].m1, vecs[v].p0, vecs[v].p1);
      pulse_start();
      check($sformatf("v%0d restart mask", v), bus.o_fail_mask, 2'b00);
      check($sformatf("v%0d restart done", v), bus.o_done, 1'b0);
      wait_done(n);
      check($sformatf("v%0d done cycle", v), n, vecs[v].exp_cyc);
      check($sformatf("v%0d done", v), bus.o_done, 1'b1);
      check($sformatf("v%0d busy", v), bus.o_busy, 1'b0);
      check($sformatf("v%0d mask", v), bus.o_fail_mask, vecs[v].exp_mask);
      check($sformatf("v%0d pass_all", v), bus.o_pass_all, vecs[v].exp_pass);
      for (int j = 0; j <= 2 * BD; j++) begin
        check($sformatf("v%0d led_r j=%0d", v, j), bus.o_led_r,
              !vecs[v].exp_pass && ((j / BD) % 2 == 0));
        check($sformatf("v%0d led_gb j=%0d", v, j), {bus.o_led_g, bus.o_led_b},
              {vecs[v].exp_pass, 1'b0});
        @(negedge clk);
      end
    end

    // restart from a failing DONE with fixtures now passing
    set_fx(M_OK, M_OK, 1'b1, 1'b1);
    pulse_start();
    check("restart mask cleared", bus.o_fail_mask, 2'b00);
    check("restart run", bus.o_run, 2'b01);
    check("restart led_r", bus.o_led_r, 1'b0);
    wait_done(n);
    check("restart done cycle", n, 14);
    check("restart pass_all", bus.o_pass_all, 1'b1);

    // reset in WAIT, then a clean rerun with a stray start mid-sequence
    pulse_start();
    repeat (3) @(negedge clk);
    check("pre-reset state", bus.dbg_state, ST_WAIT);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset state", bus.dbg_state, ST_IDLE);
    check("mid reset outs", {bus.o_run, bus.o_busy, bus.o_done, bus.o_pass_all,
          bus.o_fail_mask, bus.o_led_r, bus.o_led_g, bus.o_led_b}, 10'b0);
    pulse_start();
    check("rerun run", bus.o_run, 2'b01);
    repeat (3) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n = 4;
    while (!bus.o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rerun done cycle", n, 14);
    check("rerun pass_all", bus.o_pass_all, 1'b1);
    check("rerun mask", bus.o_fail_mask, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
